// File: rtl/proc_trace_pkg.sv
// Shared types and widths for the processor instruction-trace buffer.
// Snooped field widths are fixed here so that the entry struct, the storage
// and the read port all agree on one layout.
// Optional feature: TRACE_TRIGGER_EN adds an opcode trigger and stores the
// processor state nibble in the most significant bits of each entry.
package proc_trace_pkg;

    localparam int PC_W    = 7;
    localparam int IR_W    = 16;
    localparam int DATA_W  = 16;
    localparam int STATE_W = 4;

    // Opcode field inside the snooped instruction word
    localparam int OPCODE_HI = 15;
    localparam int OPCODE_LO = 12;

    typedef enum logic [1:0] {
        T_IDLE   = 2'd0,
        T_RUN    = 2'd1,
        T_FROZEN = 2'd2
    } tstate_e;

    // One trace record; the bit order is what the consumer sees on Rd_Data
    typedef struct packed {
`ifdef TRACE_TRIGGER_EN
        logic [STATE_W-1:0] state;
`endif
        logic [PC_W-1:0]    pc;
        logic [IR_W-1:0]    ir;
        logic [DATA_W-1:0]  alu;
    } trace_entry_t;

    localparam int ENTRY_W = $bits(trace_entry_t);

endpackage

// File: rtl/trace_ram.sv
// Trace storage: DEPTH x WIDTH, one synchronous write port and one
// asynchronous read port so the head entry can be shown ahead of the pop.
// Contents are not reset; the top masks the read data while empty.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_sys,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the captured entry into the tail slot
    always_ff @(posedge clk_sys) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/proc_trace_buffer.sv
// Instruction trace buffer for the processor.
// Snoops PC/IR/ALU and records one entry per PC change while running into a
// circular buffer that a valid/ready consumer drains (show-ahead head).
// Optional feature (macro TRACE_TRIGGER_EN): a capture whose opcode matches
// Trig_Op is stored, then freezes capture and sets the sticky Triggered flag;
// entries also carry State_In. Without the macro Triggered is tied low and
// State_In / Trig_Op are ignored.
//
// state     | meaning
// ----------+-----------------------------------------------
// T_IDLE    | after reset or Clear; no capture
// T_RUN     | capturing one entry per PC change
// T_FROZEN  | stopped by Stop or trigger; contents kept, reads allowed
module proc_trace_buffer
    import proc_trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [PC_W-1:0]          PC_In,
    input  logic [IR_W-1:0]          IR_In,
    input  logic [STATE_W-1:0]       State_In,
    input  logic [DATA_W-1:0]        ALU_In,
    input  logic                     Start,
    input  logic                     Stop,
    input  logic                     Clear,
    input  logic                     Rd_Ready,
    output logic                     Rd_Valid,
    output logic [ENTRY_W-1:0]       Rd_Data,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Overflow,
    output logic                     Running,
    input  logic [3:0]               Trig_Op,
    output logic                     Triggered
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [1:0] ST_IDLE   = T_IDLE;
    localparam logic [1:0] ST_RUN    = T_RUN;
    localparam logic [1:0] ST_FROZEN = T_FROZEN;

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [PC_W-1:0]    prev_pc_q;
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [CW-1:0]      count_q;
    logic               overflow_q;

    logic               running;
    logic               capture;
    logic               empty;
    logic               full;
    logic               pop;
    logic               do_pop;
    logic               wr_en;
    logic               drop;
    logic               trig_hit;
    logic [3:0]         ir_opcode;
    trace_entry_t       wr_entry;
    logic [ENTRY_W-1:0] ram_rdata;

    assign ir_opcode = IR_In[OPCODE_HI:OPCODE_LO];

    assign running = (state_q == ST_RUN);
    assign capture = running && (PC_In != prev_pc_q);
    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_C);

    // A pop needs a visible head; an entry captured this cycle is not yet visible
    assign pop    = !empty && Rd_Ready;
    assign do_pop = pop && !Clear;

    // When full, a same-cycle pop frees the slot the new entry lands in
    assign wr_en = capture && (!full || pop) && !Clear;
    assign drop  = capture && full && !pop;

`ifdef TRACE_TRIGGER_EN
    assign trig_hit = capture && (ir_opcode == Trig_Op);
`else
    logic unused_inputs;
    assign trig_hit      = 1'b0;
    assign unused_inputs = ^{State_In, Trig_Op, ir_opcode};
`endif

    // Assemble the record written on a capture
    always_comb begin
        wr_entry     = '0;
        wr_entry.pc  = PC_In;
        wr_entry.ir  = IR_In;
        wr_entry.alu = ALU_In;
`ifdef TRACE_TRIGGER_EN
        wr_entry.state = State_In;
`endif
    end

    // Next-state: Clear wins everywhere, Stop blocks a same-cycle Start
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (Start && !Stop)     state_d = ST_RUN;
            ST_RUN:    if (Stop || trig_hit)   state_d = ST_FROZEN;
            ST_FROZEN: if (Start && !Stop)     state_d = ST_RUN;
            default:                           state_d = ST_IDLE;
        endcase
        if (Clear) begin
            state_d = ST_IDLE;
        end
    end

    // State register and PC history (history tracks PC in every state)
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_IDLE;
            prev_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            prev_pc_q <= PC_In;
        end
    end

    // Pointers, occupancy and the sticky overflow flag
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (Clear) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({wr_en, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

`ifdef TRACE_TRIGGER_EN
    logic triggered_q;

    // Sticky trigger flag, cleared only by Clear or reset
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            triggered_q <= 1'b0;
        end else if (Clear) begin
            triggered_q <= 1'b0;
        end else if (trig_hit) begin
            triggered_q <= 1'b1;
        end
    end

    assign Triggered = triggered_q;
`else
    assign Triggered = 1'b0;
`endif

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .AW    (AW)
    ) u_ram (
        .clk_sys (Clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rdata)
    );

    // Storage is not reset, so the head is forced to zero while empty
    assign Rd_Valid = !empty;
    assign Rd_Data  = empty ? '0 : ram_rdata;
    assign Count    = count_q;
    assign Overflow = overflow_q;
    assign Running  = running;

endmodule

// File: tb/tb_proc_trace_buffer.sv
// Bench for proc_trace_buffer: directed scenarios, a queue-based reference
// model compared on every falling edge, and literal checks that pin the model.
module tb_proc_trace_buffer;
    import proc_trace_pkg::*;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int LO_W  = PC_W + IR_W + DATA_W;

    logic                 Clk;
    logic                 Reset;
    logic [PC_W-1:0]      PC_In;
    logic [IR_W-1:0]      IR_In;
    logic [STATE_W-1:0]   State_In;
    logic [DATA_W-1:0]    ALU_In;
    logic                 Start;
    logic                 Stop;
    logic                 Clear;
    logic                 Rd_Ready;
    logic                 Rd_Valid;
    logic [ENTRY_W-1:0]   Rd_Data;
    logic [CW-1:0]        Count;
    logic                 Overflow;
    logic                 Running;
    logic [3:0]           Trig_Op;
    logic                 Triggered;

    proc_trace_buffer #(.DEPTH(DEPTH)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .PC_In     (PC_In),
        .IR_In     (IR_In),
        .State_In  (State_In),
        .ALU_In    (ALU_In),
        .Start     (Start),
        .Stop      (Stop),
        .Clear     (Clear),
        .Rd_Ready  (Rd_Ready),
        .Rd_Valid  (Rd_Valid),
        .Rd_Data   (Rd_Data),
        .Count     (Count),
        .Overflow  (Overflow),
        .Running   (Running),
        .Trig_Op   (Trig_Op),
        .Triggered (Triggered)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a bounded FIFO of expected records plus mode/flags
    logic [ENTRY_W-1:0] mq[$];
    int                 m_mode;     // 0 idle, 1 running, 2 frozen
    logic               m_ovf;
    logic               m_trig;
    logic [PC_W-1:0]    m_prev;

    always @(posedge Clk or negedge Reset) begin : model
        bit m_pop;
        bit m_cap;
        bit m_hit;
        logic [ENTRY_W-1:0] ent;
        if (!Reset) begin
            mq.delete();
            m_mode = 0;
            m_ovf  = 1'b0;
            m_trig = 1'b0;
            m_prev = '0;
        end else begin
            m_pop = (mq.size() > 0) && Rd_Ready;
            m_cap = (m_mode == 1) && (PC_In != m_prev);
            m_hit = 1'b0;
`ifdef TRACE_TRIGGER_EN
            m_hit = m_cap && (IR_In[15:12] == Trig_Op);
            ent   = {State_In, PC_In, IR_In, ALU_In};
`else
            ent   = {PC_In, IR_In, ALU_In};
`endif
            if (Clear) begin
                mq.delete();
                m_ovf  = 1'b0;
                m_trig = 1'b0;
                m_mode = 0;
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_cap) begin
                    if (mq.size() < DEPTH) mq.push_back(ent);
                    else m_ovf = 1'b1;
                end
                if (m_hit) m_trig = 1'b1;
                if (Stop) begin
                    if (m_mode == 1) m_mode = 2;
                end else if (Start && m_mode != 1) begin
                    m_mode = 1;
                end else if (m_hit) begin
                    m_mode = 2;
                end
            end
            m_prev = PC_In;
        end
    end

    // Compare every output against the model away from the active edge
    always @(negedge Clk) begin
        if (chk_en) begin
            check("rd_valid",  64'(Rd_Valid),  64'(mq.size() != 0));
            check("count",     64'(Count),     64'(mq.size()));
            check("rd_data",   64'(Rd_Data),   (mq.size() != 0) ? 64'(mq[0]) : 64'd0);
            check("overflow",  64'(Overflow),  64'(m_ovf));
            check("running",   64'(Running),   64'(m_mode == 1));
            check("triggered", 64'(Triggered), 64'(m_trig));
        end
    end

    function automatic logic [63:0] head_pc();
        logic [ENTRY_W-1:0] d;
        d = Rd_Data;
        return 64'(d[LO_W-1 -: PC_W]);
    endfunction

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic set_pc(input int pc, input logic [3:0] op);
        PC_In    = PC_W'(pc);
        IR_In    = {op, 12'(pc)};
        ALU_In   = 16'hA000 + 16'(pc);
        State_In = 4'(pc + 3);
    endtask

    task automatic pulse_start();
        Start = 1'b1; tick(); Start = 1'b0;
    endtask

    task automatic pulse_stop();
        Stop = 1'b1; tick(); Stop = 1'b0;
    endtask

    task automatic pulse_clear();
        Clear = 1'b1; tick(); Clear = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"},     64'(Count),     64'd0);
        check({tag, "_valid"},     64'(Rd_Valid),  64'd0);
        check({tag, "_data"},      64'(Rd_Data),   64'd0);
        check({tag, "_overflow"},  64'(Overflow),  64'd0);
        check({tag, "_running"},   64'(Running),   64'd0);
        check({tag, "_triggered"}, 64'(Triggered), 64'd0);
    endtask

    initial begin
        Reset    = 1'b0;
        PC_In    = '0;
        IR_In    = '0;
        State_In = '0;
        ALU_In   = '0;
        Start    = 1'b0;
        Stop     = 1'b0;
        Clear    = 1'b0;
        Rd_Ready = 1'b0;
        Trig_Op  = 4'hF;

        repeat (2) @(posedge Clk);
        #2;
        check_reset_outputs("reset");
        Reset  = 1'b1;
        chk_en = 1'b1;
        tick();

        // 1: three PC steps, then drain in order
        pulse_start();
        for (int pc = 1; pc <= 3; pc++) begin
            set_pc(pc, 4'h1);
            tick();
        end
        pulse_stop();
        check("t1_count", 64'(Count), 64'd3);
        check("t1_running", 64'(Running), 64'd0);
        Rd_Ready = 1'b1;
        #1;
        check("t1_pop0_pc", head_pc(), 64'd1);
        tick();
        check("t1_pop1_pc", head_pc(), 64'd2);
        tick();
        check("t1_pop2_pc", head_pc(), 64'd3);
        tick();
        Rd_Ready = 1'b0;
        check("t1_empty", 64'(Rd_Valid), 64'd0);

        // 2: 20 captures into 16 slots, no reads
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            set_pc(10 + i, 4'h2);
            tick();
        end
        check("t2_count", 64'(Count), 64'd16);
        check("t2_overflow", 64'(Overflow), 64'd1);
        check("t2_head_pc", head_pc(), 64'd10);
        pulse_clear();
        check("t2_clear_count", 64'(Count), 64'd0);
        check("t2_clear_overflow", 64'(Overflow), 64'd0);

        // 3: full buffer, capture and pop in the same cycle
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            set_pc(40 + i, 4'h3);
            tick();
        end
        check("t3_full_count", 64'(Count), 64'd16);
        Rd_Ready = 1'b1;
        set_pc(56, 4'h3);
        tick();
        Rd_Ready = 1'b0;
        check("t3_count", 64'(Count), 64'd16);
        check("t3_overflow", 64'(Overflow), 64'd0);
        check("t3_head_pc", head_pc(), 64'd41);
        Rd_Ready = 1'b1;
        repeat (15) tick();
        check("t3_tail_pc", head_pc(), 64'd56);
        tick();
        Rd_Ready = 1'b0;
        check("t3_drained", 64'(Count), 64'd0);

        // 4: Start and Clear together with five entries held
        pulse_clear();
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            set_pc(60 + i, 4'h4);
            tick();
        end
        check("t4_count5", 64'(Count), 64'd5);
        Start = 1'b1;
        Clear = 1'b1;
        tick();
        Start = 1'b0;
        Clear = 1'b0;
        check("t4_count", 64'(Count), 64'd0);
        check("t4_valid", 64'(Rd_Valid), 64'd0);
        check("t4_running", 64'(Running), 64'd0);

        // 5: asynchronous reset mid-run with seven entries
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            set_pc(70 + i, 4'h5);
            tick();
        end
        check("t5_count7", 64'(Count), 64'd7);
        Reset = 1'b0;
        #1;
        check_reset_outputs("t5");
        tick();
        Reset = 1'b1;
        tick();

        // 6: opcode trigger stream 1,2,F,3
        pulse_start();
        set_pc(80, 4'h1); tick();
        set_pc(81, 4'h2); tick();
        set_pc(82, 4'hF); tick();
        set_pc(83, 4'h3); tick();
`ifdef TRACE_TRIGGER_EN
        check("t6_count", 64'(Count), 64'd3);
        check("t6_triggered", 64'(Triggered), 64'd1);
        check("t6_running", 64'(Running), 64'd0);
`else
        check("t6_count", 64'(Count), 64'd4);
        check("t6_triggered", 64'(Triggered), 64'd0);
        check("t6_running", 64'(Running), 64'd1);
`endif
        pulse_stop();
        Rd_Ready = 1'b1;
        repeat (5) tick();
        Rd_Ready = 1'b0;
        check("t6_drained", 64'(Count), 64'd0);
        tick();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
